// File: rtl/fir_mac_sequencer_pkg.sv
// Shared widths, default sizing and FSM encoding for the FIR MAC sequencer.
package fir_mac_sequencer_pkg;

  localparam int SM_W      = 11;
  localparam int PROD_W    = 21;
  localparam int DEF_NTAPS = 16;
  localparam int DEF_ACC_W = 26;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

endpackage

// File: rtl/fir_mac_sequencer_sm_to_tc.sv
// Converts a sign-magnitude product into a sign-extended two's-complement term.
module sm_to_tc
  import fir_mac_sequencer_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [PROD_W-1:0] i_sm,
  output logic [ACC_W-1:0]  o_tc
);

  logic [PROD_W-2:0] w_mag;
  logic [ACC_W-1:0]  w_ext;

  assign w_mag = i_sm[PROD_W-2:0];
  assign w_ext = {{(ACC_W-PROD_W+1){1'b0}}, w_mag};

  // A zero magnitude maps to zero regardless of sign, so negative zero adds nothing.
  assign o_tc = (w_mag == '0) ? '0 : (i_sm[PROD_W-1] ? -w_ext : w_ext);

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequential FIR engine: one tap per cycle through an external sign-magnitude
// multiplier, two's-complement accumulation, one result strobe per sample.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int ACC_W = DEF_ACC_W,
  localparam int TAP_W = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SM_W-1:0]   sample_in,
  input  logic              sample_valid,
  input  logic              coef_we,
  input  logic [TAP_W-1:0]  coef_addr,
  input  logic [SM_W-1:0]   coef_wdata,
  output logic [SM_W-1:0]   mul_a,
  output logic [SM_W-1:0]   mul_b,
  output logic              mul_en,
  input  logic [PROD_W-1:0] mul_out,
  output logic [ACC_W-1:0]  y_out,
  output logic              y_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

  state_t           r_state;
  logic [TAP_W-1:0] r_tap;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_y;
  logic             r_y_valid;
  logic             r_overrun;
  logic [SM_W-1:0]  r_x    [NTAPS];
  logic [SM_W-1:0]  r_coef [NTAPS];

  logic             w_mac;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_sum;

  assign w_mac  = (r_state == ST_MAC);
  assign mul_en = w_mac;
  assign mul_a  = w_mac ? r_x[r_tap]    : '0;
  assign mul_b  = w_mac ? r_coef[r_tap] : '0;

  sm_to_tc #(.ACC_W(ACC_W)) u_sm_to_tc (
    .i_sm (mul_out),
    .o_tc (w_term)
  );

  assign w_sum = r_acc + w_term;

  // Coefficient writes land at the clock edge, so a tap being read this cycle still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
    end else if (coef_we) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tap     <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
    end else begin
      r_y_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sample_valid) begin
            for (int k = NTAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0]  <= sample_in;
            r_tap   <= '0;
            r_acc   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          // Samples arriving mid-computation are discarded and flagged until reset.
          if (sample_valid) r_overrun <= 1'b1;
          r_acc <= w_sum;
          r_tap <= r_tap + TAP_W'(1);
          if (r_tap == LAST_TAP) begin
            r_y       <= w_sum;
            r_y_valid <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign y_out   = r_y;
  assign y_valid = r_y_valid;
  assign busy    = w_mac;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench: models the external multiplier and scores every y_out
// against expected values queued when each sample is driven.
module tb_fir_mac_sequencer;

  localparam int NTAPS = 16;
  localparam int ACC_W = 26;

  logic              clk = 1'b0;
  logic              rstN;
  logic [10:0]       sampleIn;
  logic              sampleValid;
  logic              coefWe;
  logic [3:0]        coefAddr;
  logic [10:0]       coefWdata;
  logic [10:0]       mulA;
  logic [10:0]       mulB;
  logic              mulEn;
  logic [20:0]       mulOut;
  logic [ACC_W-1:0]  yOut;
  logic              yValid;
  logic              busy;
  logic              overrun;

  typedef struct {
    logic [10:0] sample;
    int          expY;
  } vec_t;

  vec_t vecs[4];
  int   expQ[$];
  int   mx[NTAPS];
  int   mc[NTAPS];
  int   nChecks = 0;
  int   nPass   = 0;
  int   popped;
  int   lat;
  int   busyCnt;
  int   cnt;

  fir_mac_sequencer #(.NTAPS(NTAPS), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .sample_in    (sampleIn),
    .sample_valid (sampleValid),
    .coef_we      (coefWe),
    .coef_addr    (coefAddr),
    .coef_wdata   (coefWdata),
    .mul_a        (mulA),
    .mul_b        (mulB),
    .mul_en       (mulEn),
    .mul_out      (mulOut),
    .y_out        (yOut),
    .y_valid      (yValid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // External sign-magnitude multiplier, idle output when not enabled.
  always_comb begin
    mulOut = '0;
    if (mulEn) mulOut = {mulA[10] ^ mulB[10], 20'(mulA[9:0]) * 20'(mulB[9:0])};
  end

  function automatic int smToInt(input logic [10:0] v);
    return v[10] ? -int'(v[9:0]) : int'(v[9:0]);
  endfunction

  function automatic logic [10:0] intToSm(input int v);
    return (v < 0) ? {1'b1, 10'(-v)} : {1'b0, 10'(v)};
  endfunction

  function automatic int modelY();
    int s = 0;
    for (int k = 0; k < NTAPS; k++) s += mc[k] * mx[k];
    return s;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nChecks++;
    if (actual == expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Scoreboard consumer: every result strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstN && yValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected y_valid", 1, 0);
      end else begin
        popped = expQ.pop_front();
        checkOutput("y_out", longint'($signed(yOut)), longint'(popped));
      end
    end
  end

  task automatic clearModel();
    expQ.delete();
    for (int k = 0; k < NTAPS; k++) begin
      mx[k] = 0;
      mc[k] = 0;
    end
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clearModel();
    rstN = 1'b1;
  endtask

  task automatic writeCoef(input int addr, input logic [10:0] sm);
    coefWe    = 1'b1;
    coefAddr  = 4'(addr);
    coefWdata = sm;
    @(posedge clk);
    #1;
    coefWe = 1'b0;
    mc[addr] = smToInt(sm);
  endtask

  task automatic driveSample(input logic [10:0] sm);
    sampleIn    = sm;
    sampleValid = 1'b1;
    @(posedge clk);
    #1;
    sampleValid = 1'b0;
  endtask

  // Accepted sample: shift the model delay line and queue the expected result.
  task automatic applyStimulus(input logic [10:0] sm, input int expY, input bit useModel);
    for (int k = NTAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = smToInt(sm);
    expQ.push_back(useModel ? modelY() : expY);
    driveSample(sm);
  endtask

  // Called one step after the accepting edge; returns at the negedge of the strobe cycle.
  task automatic waitValid(input string name, output int latency, output int busyCycles);
    bit seen = 1'b0;
    latency = 0;
    busyCycles = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (yValid) begin
        seen = 1'b1;
        latency = c;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput({name, " y_valid seen"}, longint'(seen), 1);
  endtask

  initial begin
    vecs[0] = '{11'h064, 100};
    vecs[1] = '{11'h432, 50};
    vecs[2] = '{11'h014, 70};
    vecs[3] = '{11'h40A, 60};

    rstN = 1'b1; sampleIn = '0; sampleValid = 1'b0;
    coefWe = 1'b0; coefAddr = '0; coefWdata = '0;
    clearModel();
    #2;
    resetDut();

    checkOutput("reset busy", busy, 0);
    checkOutput("reset y_valid", yValid, 0);
    checkOutput("reset overrun", overrun, 0);
    checkOutput("reset y_out", yOut, 0);
    checkOutput("reset mul_en", mulEn, 0);
    checkOutput("reset mul_a", mulA, 0);

    // Single tap, latency and busy duration.
    writeCoef(0, 11'h003);
    applyStimulus(11'h005, 15, 1'b0);
    waitValid("single tap", lat, busyCnt);
    checkOutput("latency cycles", lat, 17);
    checkOutput("busy cycles", busyCnt, 16);
    @(posedge clk); #1;
    checkOutput("y_out holds", yOut, 15);

    // Unity coefficients, back-to-back samples from the table.
    resetDut();
    for (int k = 0; k < NTAPS; k++) writeCoef(k, 11'h001);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].sample, vecs[i].expY, 1'b0);
      waitValid("unity table", lat, busyCnt);
    end
    checkOutput("overrun after y_valid accepts", overrun, 0);

    // Maximum-magnitude products, negative times negative.
    resetDut();
    writeCoef(0, 11'h7FF);
    writeCoef(1, 11'h7FF);
    applyStimulus(11'h7FF, 1046529, 1'b0);
    waitValid("negmax 1", lat, busyCnt);
    applyStimulus(11'h7FF, 2093058, 1'b0);
    waitValid("negmax 2", lat, busyCnt);
    resetDut();
    for (int k = 0; k < NTAPS; k++) writeCoef(k, 11'h3FF);
    for (int i = 1; i <= NTAPS; i++) begin
      applyStimulus(11'h3FF, i * 1046529, 1'b0);
      waitValid("allmax", lat, busyCnt);
    end
    checkOutput("allmax final y_out", longint'($signed(yOut)), 16744464);

    // Overrun: second sample three cycles in is dropped.
    resetDut();
    writeCoef(0, 11'h001);
    applyStimulus(11'h009, 9, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    driveSample(11'h032);
    waitValid("overrun run", lat, busyCnt);
    checkOutput("overrun set", overrun, 1);
    applyStimulus(11'h004, 4, 1'b0);
    checkOutput("busy after coincident accept", busy, 1);
    waitValid("coincident accept", lat, busyCnt);
    checkOutput("overrun sticky", overrun, 1);

    // Reset in the middle of a MAC run aborts it.
    writeCoef(0, 11'h003);
    writeCoef(1, 11'h005);
    applyStimulus(11'h00B, 53, 1'b0);
    waitValid("pre-abort", lat, busyCnt);
    @(posedge clk); #1;
    driveSample(11'h002);
    repeat (7) begin @(posedge clk); #1; end
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort y_valid", yValid, 0);
    checkOutput("abort overrun", overrun, 0);
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    cnt = 0;
    repeat (24) begin
      @(negedge clk);
      if (yValid) cnt++;
    end
    checkOutput("no y_valid after abort", cnt, 0);
    #1;
    writeCoef(0, 11'h003);
    writeCoef(1, 11'h005);
    applyStimulus(11'h007, 21, 1'b0);
    waitValid("post-abort", lat, busyCnt);

    // Negative zero sample, then a coefficient rewrite while that tap is being read.
    resetDut();
    writeCoef(0, 11'h007);
    applyStimulus(11'h400, 0, 1'b0);
    waitValid("negzero", lat, busyCnt);
    applyStimulus(11'h00A, 70, 1'b0);
    waitValid("after negzero", lat, busyCnt);
    applyStimulus(11'h003, 21, 1'b0);
    writeCoef(0, 11'h064);
    waitValid("old coef in use", lat, busyCnt);
    applyStimulus(11'h001, 100, 1'b0);
    waitValid("new coef in use", lat, busyCnt);

    // Random coefficients and samples against the dot-product model.
    resetDut();
    for (int k = 0; k < NTAPS; k++) writeCoef(k, 11'($urandom_range(0, 2047)));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(11'($urandom_range(0, 2047)), 0, 1'b1);
      waitValid("random", lat, busyCnt);
    end
    for (int k = 0; k < NTAPS; k++) writeCoef(k, intToSm(1023));
    for (int i = 0; i < NTAPS; i++) begin
      applyStimulus(intToSm(-1023), 0, 1'b1);
      waitValid("allneg", lat, busyCnt);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
